// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver producing a held command byte with a one-cycle strobe.
// Framing errors pulse frame_err and leave cmd untouched.
module uart_cmd_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned N    = CLK_FREQ / BAUD;
  localparam int unsigned HALF = N / 2;
  localparam int unsigned CW   = $clog2(N);

  localparam logic [CW-1:0] CntFull = CW'(N - 1);
  localparam logic [CW-1:0] CntHalf = CW'(HALF - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bidx_q;
  logic [7:0]      sr_q;
  logic            sync1_q;
  logic            rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s    <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bidx_q    <= '0;
      sr_q      <= '0;
      cmd       <= 8'h00;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          // Half-bit wait puts every later sample in the middle of its bit
          if (cnt_q == CntHalf) begin
            if (!rx_s) begin
              state_q <= StData;
              cnt_q   <= '0;
              bidx_q  <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == CntFull) begin
            sr_q  <= {rx_s, sr_q[7:1]};
            cnt_q <= '0;
            if (bidx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bidx_q <= bidx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == CntFull) begin
            cnt_q <= '0;
            if (rx_s) begin
              cmd       <= sr_q;
              cmd_valid <= 1'b1;
              state_q   <= StIdle;
            end else begin
              frame_err <= 1'b1;
              state_q   <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBreak: begin
          // Hold off until the line recovers so a break is not read as 0x00 frames
          if (rx_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomised bench for uart_cmd_rx: builds per-cycle rx/reset waveforms and
// predicts strobes, busy and cmd from frame start times and bit-period arithmetic.
module tb_uart_cmd_rx;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;

  localparam int KGood   = 0;
  localparam int KErr    = 1;
  localparam int KGlitch = 2;
  localparam int KCut    = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       frame_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int         kind;
    int         s;
    int         r;
    logic [7:0] d;
  } ev_t;

  logic        wave[$];
  logic        rstw[$];
  ev_t         evs[$];
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  logic [7:0]  cur_cmd = 8'h00;

  always #5 clk = ~clk;

  uart_cmd_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_stim();
    wave.delete();
    rstw.delete();
    evs.delete();
  endtask

  task automatic add_level(input logic lvl, input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      wave.push_back(lvl);
      rstw.push_back(r);
    end
  endtask

  task automatic add_frame(input logic [7:0] d, input logic stop);
    ev_t e;
    e.kind = stop ? KGood : KErr;
    e.s    = wave.size();
    e.r    = 0;
    e.d    = d;
    evs.push_back(e);
    add_level(1'b0, 10, 1'b1);
    for (int b = 0; b < 8; b++) add_level(d[b], 10, 1'b1);
    add_level(stop, 10, 1'b1);
  endtask

  task automatic add_glitch(input int n);
    ev_t e;
    e.kind = KGlitch;
    e.s    = wave.size();
    e.r    = 0;
    e.d    = 8'h00;
    evs.push_back(e);
    add_level(1'b0, n, 1'b1);
  endtask

  // Frame truncated after 'cut' cycles by a reset lasting rlen cycles
  task automatic add_cut(input logic [7:0] d, input int cut, input int rlen);
    ev_t e;
    e.kind = KCut;
    e.s    = wave.size();
    e.r    = e.s + cut;
    e.d    = d;
    evs.push_back(e);
    for (int j = 0; j < cut; j++) begin
      if (j < 10) add_level(1'b0, 1, 1'b1);
      else        add_level(d[(j - 10) / 10], 1, 1'b1);
    end
    add_level(1'b1, rlen, 1'b0);
  endtask

  // Pin changes at cycle i are observed at the sync output two edges later and
  // acted on by IDLE one edge after that, so a frame starting at s strobes at s+98.
  task automatic build_expect();
    int         L;
    int         h;
    logic       c_v[];
    logic       c_fe[];
    logic       c_by[];
    logic       setf[];
    logic [7:0] setd[];
    logic [7:0] c;
    L    = wave.size();
    c_v  = new[L];
    c_fe = new[L];
    c_by = new[L];
    setf = new[L];
    setd = new[L];
    for (int i = 0; i < L; i++) begin
      c_v[i] = 1'b0; c_fe[i] = 1'b0; c_by[i] = 1'b0; setf[i] = 1'b0; setd[i] = 8'h00;
    end
    foreach (evs[k]) begin
      case (evs[k].kind)
        KGood: begin
          for (int i = evs[k].s + 3; i <= evs[k].s + 97 && i < L; i++) c_by[i] = 1'b1;
          if (evs[k].s + 98 < L) begin
            c_v[evs[k].s + 98]  = 1'b1;
            setf[evs[k].s + 98] = 1'b1;
            setd[evs[k].s + 98] = evs[k].d;
          end
        end
        KErr: begin
          h = evs[k].s + 90;
          while (h < L && wave[h] !== 1'b1) h++;
          for (int i = evs[k].s + 3; i <= h + 2 && i < L; i++) c_by[i] = 1'b1;
          if (evs[k].s + 98 < L) c_fe[evs[k].s + 98] = 1'b1;
        end
        KGlitch: begin
          for (int i = evs[k].s + 3; i <= evs[k].s + 7 && i < L; i++) c_by[i] = 1'b1;
        end
        default: begin
          for (int i = evs[k].s + 3; i < evs[k].r && i < L; i++) c_by[i] = 1'b1;
        end
      endcase
    end
    exp_q.delete();
    c = cur_cmd;
    for (int i = 0; i < L; i++) begin
      if (!rstw[i])     c = 8'h00;
      else if (setf[i]) c = setd[i];
      exp_q.push_back({c_v[i], c_fe[i], c_by[i], c});
    end
    cur_cmd = c;
  endtask

  task automatic play();
    obs_q.delete();
    for (int i = 0; i < wave.size(); i++) begin
      @(posedge clk);
      #1;
      rx    = wave[i];
      rst_n = rstw[i];
      @(negedge clk);
      obs_q.push_back({cmd_valid, frame_err, busy, cmd});
    end
  endtask

  task automatic test_reset();
    int errs = 0;
    clear_stim();
    for (int i = 0; i < 18; i++) add_level(1'($urandom_range(0, 1)), 1, 1'b0);
    add_level(1'b1, 2, 1'b0);
    add_level(1'b1, 20, 1'b1);
    build_expect();
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        if (errs < 8) $display("FAIL reset cyc %0d: v/fe/busy/cmd got %b/%b/%b/%h want %b/%b/%b/%h",
          i, obs_q[i][10], obs_q[i][9], obs_q[i][8], obs_q[i][7:0],
          exp_q[i][10], exp_q[i][9], exp_q[i][8], exp_q[i][7:0]);
        errs++;
      end
    end
  endtask

  task automatic test_single();
    int errs = 0;
    clear_stim();
    add_level(1'b1, 5, 1'b1);
    add_frame(8'h31, 1'b1);
    add_level(1'b1, 15, 1'b1);
    build_expect();
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        if (errs < 8) $display("FAIL single cyc %0d: v/fe/busy/cmd got %b/%b/%b/%h want %b/%b/%b/%h",
          i, obs_q[i][10], obs_q[i][9], obs_q[i][8], obs_q[i][7:0],
          exp_q[i][10], exp_q[i][9], exp_q[i][8], exp_q[i][7:0]);
        errs++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    clear_stim();
    add_level(1'b1, 3, 1'b1);
    add_frame(8'h30, 1'b1);
    add_frame(8'h34, 1'b1);
    add_level(1'b1, 15, 1'b1);
    build_expect();
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        if (errs < 8) $display("FAIL b2b cyc %0d: v/fe/busy/cmd got %b/%b/%b/%h want %b/%b/%b/%h",
          i, obs_q[i][10], obs_q[i][9], obs_q[i][8], obs_q[i][7:0],
          exp_q[i][10], exp_q[i][9], exp_q[i][8], exp_q[i][7:0]);
        errs++;
      end
    end
  endtask

  task automatic test_glitch();
    int errs = 0;
    clear_stim();
    add_level(1'b1, 3, 1'b1);
    add_glitch(3);
    add_level(1'b1, 15, 1'b1);
    build_expect();
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        if (errs < 8) $display("FAIL glitch cyc %0d: v/fe/busy/cmd got %b/%b/%b/%h want %b/%b/%b/%h",
          i, obs_q[i][10], obs_q[i][9], obs_q[i][8], obs_q[i][7:0],
          exp_q[i][10], exp_q[i][9], exp_q[i][8], exp_q[i][7:0]);
        errs++;
      end
    end
  endtask

  task automatic test_frame_err();
    int errs = 0;
    clear_stim();
    add_level(1'b1, 3, 1'b1);
    add_frame(8'h55, 1'b0);
    add_level(1'b0, 50, 1'b1);
    add_level(1'b1, 20, 1'b1);
    add_frame(8'h32, 1'b1);
    add_level(1'b1, 15, 1'b1);
    build_expect();
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        if (errs < 8) $display("FAIL frame_err cyc %0d: v/fe/busy/cmd got %b/%b/%b/%h want %b/%b/%b/%h",
          i, obs_q[i][10], obs_q[i][9], obs_q[i][8], obs_q[i][7:0],
          exp_q[i][10], exp_q[i][9], exp_q[i][8], exp_q[i][7:0]);
        errs++;
      end
    end
  endtask

  task automatic test_reset_mid_data();
    int errs = 0;
    clear_stim();
    add_level(1'b1, 3, 1'b1);
    add_cut(8'h33, 55, 3);
    add_level(1'b1, 30, 1'b1);
    add_frame(8'h33, 1'b1);
    add_level(1'b1, 15, 1'b1);
    build_expect();
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        if (errs < 8) $display("FAIL rst_mid cyc %0d: v/fe/busy/cmd got %b/%b/%b/%h want %b/%b/%b/%h",
          i, obs_q[i][10], obs_q[i][9], obs_q[i][8], obs_q[i][7:0],
          exp_q[i][10], exp_q[i][9], exp_q[i][8], exp_q[i][7:0]);
        errs++;
      end
    end
  endtask

  task automatic test_random();
    int errs = 0;
    clear_stim();
    for (int f = 0; f < 10; f++) begin
      add_level(1'b1, $urandom_range(0, 12), 1'b1);
      add_frame(8'($urandom), 1'b1);
    end
    add_level(1'b1, 15, 1'b1);
    build_expect();
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        if (errs < 8) $display("FAIL random cyc %0d: v/fe/busy/cmd got %b/%b/%b/%h want %b/%b/%b/%h",
          i, obs_q[i][10], obs_q[i][9], obs_q[i][8], obs_q[i][7:0],
          exp_q[i][10], exp_q[i][9], exp_q[i][8], exp_q[i][7:0]);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_data();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
